// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares the write port of one FIFO between NUM_REQ producers. Arbitration
//   is round-robin, and the winner keeps the port for a burst of up to
//   BURST_LEN beats. The block keeps its own occupancy count (writes minus
//   observed read fires), so back-pressure never depends combinationally on
//   the FIFO's full flag.
//
// Handshake: a requester beat is accepted on a clock edge where
//   req_valid[i] && req_ready[i]. req_ready is one-hot-or-zero. A producer
//   must hold req_data stable while valid && !ready. fifo_wr_en/fifo_data_in
//   mirror the accepted beat in the same cycle.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   req_valid     per-requester data valid
//   req_data      requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready     one-hot-or-zero accept
//   fifo_wr_en    FIFO write enable
//   fifo_data_in  FIFO write data (zero outside a beat)
//   fifo_rd_fire  consumer read accepted this cycle
//   fifo_level    tracked occupancy, 0..DEPTH
//   grant_id      current or last granted requester
//   busy          high while a burst is granted
//   underflow     sticky; a read fire was seen at level 0
//   fsm_state     debug view of the FSM state (0 = IDLE, 1 = BURST)
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 6,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_rd_fire,
  output logic [CNT_WIDTH-1:0]          fifo_level,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy,
  output logic                          underflow,
  output logic                          fsm_state
);

  localparam logic IDLE  = 1'b0;
  localparam logic BURST = 1'b1;

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0]    LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_LEVEL = CNT_WIDTH'(DEPTH);
  localparam logic [ID_WIDTH-1:0]  LAST_ID    = ID_WIDTH'(NUM_REQ - 1);

  logic                 state;
  logic [BEAT_W-1:0]    beat_cnt;
  logic [ID_WIDTH-1:0]  last_grant;
  logic [CNT_WIDTH-1:0] level;

  logic [ID_WIDTH-1:0]  winner;
  logic                 any_valid;
  logic                 can_write;
  logic                 beat;
  logic                 burst_end;

  // Round-robin search starting just after the previous winner, so the
  // requester that was served last has the lowest priority.
  always_comb begin
    winner    = last_grant;
    any_valid = |req_valid;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req_valid[(int'(last_grant) + i) % NUM_REQ]) begin
        winner = ID_WIDTH'((int'(last_grant) + i) % NUM_REQ);
      end
    end
  end

  // Ready looks only at the registered level: a read in the same cycle
  // frees space for the next cycle, not this one.
  assign can_write = (state == BURST) && (level < FULL_LEVEL);
  assign beat      = can_write && req_valid[grant_id];
  assign burst_end = (state == BURST) &&
                     ((beat && (beat_cnt == LAST_BEAT)) || !req_valid[grant_id]);

  always_comb begin
    req_ready = '0;
    if (can_write) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign fifo_wr_en   = beat;
  assign fifo_data_in = beat ? req_data[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      last_grant <= LAST_ID;
      grant_id   <= LAST_ID;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_id <= winner;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
          if (burst_end) begin
            last_grant <= grant_id;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Occupancy: a simultaneous beat and read cancel out. A read at level 0
  // cannot be real, so it is flagged instead of wrapping the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level     <= '0;
      underflow <= 1'b0;
    end else begin
      if (fifo_rd_fire && (level == '0)) begin
        underflow <= 1'b1;
      end
      if (beat && !fifo_rd_fire) begin
        level <= level + 1'b1;
      end else if (!beat && fifo_rd_fire && (level != '0)) begin
        level <= level - 1'b1;
      end
    end
  end

  assign fifo_level = level;
  assign busy       = (state == BURST);
  assign fsm_state  = state;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int BL    = 4;
  localparam int CW    = 6;
  localparam int IW    = 2;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_data_in;
  logic            fifo_rd_fire;
  logic [CW-1:0]   fifo_level;
  logic [IW-1:0]   grant_id;
  logic            busy;
  logic            underflow;
  logic            fsm_state;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .DEPTH(DEPTH), .BURST_LEN(BL),
    .CNT_WIDTH(CW), .ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .fifo_rd_fire(fifo_rd_fire), .fifo_level(fifo_level), .grant_id(grant_id),
    .busy(busy), .underflow(underflow), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks who holds the port, how many beats it has taken, and the
  // occupancy as a plain integer.
  bit m_busy;
  int m_g, m_last, m_beats, m_level;
  bit m_uf;

  task automatic model_reset();
    m_busy = 0; m_g = N - 1; m_last = N - 1; m_beats = 0; m_level = 0; m_uf = 0;
  endtask

  // outputs sampled by the last step
  logic [N-1:0]  s_ready;
  logic          s_wr;
  logic [DW-1:0] s_data;
  logic [CW-1:0] s_level;
  logic [IW-1:0] s_grant;
  logic          s_busy;
  logic          s_uf;

  // One clock cycle: drive on the falling edge, compare mid-low-phase,
  // advance the model, and return just after the rising edge.
  task automatic step(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic rd);
    int  e_ready, e_data, idx;
    bit  beat, found;
    @(negedge clk);
    req_valid = v; req_data = d; fifo_rd_fire = rd;
    #1;
    e_ready = (m_busy && m_level < DEPTH) ? (1 << m_g) : 0;
    beat    = m_busy && (m_level < DEPTH) && v[m_g];
    e_data  = beat ? int'((d >> (DW * m_g)) & 32'hFF) : 0;
    s_ready = req_ready; s_wr = fifo_wr_en; s_data = fifo_data_in;
    s_level = fifo_level; s_grant = grant_id; s_busy = busy; s_uf = underflow;
    check("model", {req_ready, fifo_wr_en, fifo_data_in, fifo_level, grant_id, busy, underflow, fsm_state},
          {4'(e_ready), beat, 8'(e_data), 6'(m_level), 2'(m_g), m_busy, m_uf, m_busy});
    if (rd && m_level == 0) m_uf = 1;
    m_level = m_level + int'(beat) - int'(rd);
    if (m_level < 0) m_level = 0;
    if (!m_busy) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (!found && v[idx]) begin
          found = 1; m_g = idx; m_busy = 1; m_beats = 0;
        end
      end
    end else if (beat) begin
      m_beats++;
      if (m_beats == BL) begin m_busy = 0; m_last = m_g; end
    end else if (!v[m_g]) begin
      m_busy = 0; m_last = m_g;
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; req_valid = '0; req_data = '0; fifo_rd_fire = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {req_ready, fifo_wr_en, fifo_data_in, fifo_level, busy, underflow, fsm_state}, 64'd0);
    check("reset_grant", grant_id, 64'd3);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [N-1:0]  v;
    logic [7:0]    d;
    logic [N-1:0]  ready;
    logic          wr;
    logic [7:0]    data;
    logic [CW-1:0] level;
    logic [IW-1:0] grant;
    logic          bsy;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(logic [N-1:0] v, logic [7:0] d, logic [N-1:0] r, logic w,
                              logic [7:0] o, logic [CW-1:0] l, logic [IW-1:0] g, logic b);
    vec_t t;
    t.v = v; t.d = d; t.ready = r; t.wr = w; t.data = o; t.level = l; t.grant = g; t.bsy = b;
    return t;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst = 1'b0; req_valid = '0; req_data = '0; fifo_rd_fire = 1'b0;

    // single requester, 6 beats split into a 4-beat and a 2-beat burst
    tbl[0] = mk(4'b0001, 8'h10, 4'b0000, 0, 8'h00, 6'd0, 2'd3, 0);
    tbl[1] = mk(4'b0001, 8'h10, 4'b0001, 1, 8'h10, 6'd0, 2'd0, 1);
    tbl[2] = mk(4'b0001, 8'h11, 4'b0001, 1, 8'h11, 6'd1, 2'd0, 1);
    tbl[3] = mk(4'b0001, 8'h12, 4'b0001, 1, 8'h12, 6'd2, 2'd0, 1);
    tbl[4] = mk(4'b0001, 8'h13, 4'b0001, 1, 8'h13, 6'd3, 2'd0, 1);
    tbl[5] = mk(4'b0001, 8'h14, 4'b0000, 0, 8'h00, 6'd4, 2'd0, 0);
    tbl[6] = mk(4'b0001, 8'h14, 4'b0001, 1, 8'h14, 6'd4, 2'd0, 1);
    tbl[7] = mk(4'b0001, 8'h15, 4'b0001, 1, 8'h15, 6'd5, 2'd0, 1);
    tbl[8] = mk(4'b0000, 8'h00, 4'b0001, 0, 8'h00, 6'd6, 2'd0, 1);
    tbl[9] = mk(4'b0000, 8'h00, 4'b0000, 0, 8'h00, 6'd6, 2'd0, 0);

    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, {8'hAA, 8'hBB, 8'hCC, tbl[i].d}, 1'b0);
      check($sformatf("table[%0d]", i), {s_ready, s_wr, s_data, s_level, s_grant, s_busy},
            {tbl[i].ready, tbl[i].wr, tbl[i].data, tbl[i].level, tbl[i].grant, tbl[i].bsy});
    end

    // all requesters valid: 0,1,2,3,0 with 4 beats per burst and 1 idle cycle
    do_reset();
    for (int c = 0; c < 21; c++) begin
      step(4'b1111, $urandom, 1'b0);
      check("rr_wr", s_wr, ((c % 5) != 0) ? 64'd1 : 64'd0);
      if (s_wr) check("rr_grant", s_grant, 64'((c / 5) % 4));
    end

    // fill to DEPTH, then one read frees exactly one more beat
    do_reset();
    for (int c = 0; c < 40; c++) step(4'b0010, $urandom, 1'b0);
    step(4'b0010, $urandom, 1'b0);
    check("full_level", s_level, 64'd32);
    step(4'b0010, $urandom, 1'b0);
    check("full_stall", {s_ready, s_busy}, {4'b0000, 1'b1});
    step(4'b0010, $urandom, 1'b1);
    check("full_rd_same_cycle", {s_ready, s_wr}, {4'b0000, 1'b0});
    step(4'b0010, $urandom, 1'b0);
    check("full_after_rd", {s_ready, s_wr, s_level}, {4'b0010, 1'b1, 6'd31});
    step(4'b0010, $urandom, 1'b0);
    check("full_again", {s_ready, s_level}, {4'b0000, 6'd32});

    // simultaneous beat + read at level 10, then underflow
    do_reset();
    for (int c = 0; c < 30 && m_level < 10; c++) step(4'b0001, $urandom, 1'b0);
    step(4'b0001, $urandom, 1'b1);
    check("beat_and_rd_wr", s_wr, 64'd1);
    step(4'b0000, '0, 1'b0);
    check("beat_and_rd_level", s_level, 64'd10);
    for (int c = 0; c < 12; c++) step(4'b0000, '0, (m_level > 0));
    check("drained", {s_level, s_uf}, {6'd0, 1'b0});
    step(4'b0000, '0, 1'b1);
    step(4'b0000, '0, 1'b0);
    check("underflow_set", {s_level, s_uf}, {6'd0, 1'b1});
    repeat (3) step(4'b0000, '0, 1'b0);
    check("underflow_sticky", s_uf, 64'd1);

    // requester 2 drops valid after 2 beats; 0 wins next, not 2
    do_reset();
    repeat (3) step(4'b0100, $urandom, 1'b0);
    step(4'b0001, $urandom, 1'b0);
    check("drop_valid_wr", s_wr, 64'd0);
    step(4'b0101, $urandom, 1'b0);
    check("drop_valid_idle", s_busy, 64'd0);
    step(4'b0101, $urandom, 1'b0);
    check("drop_valid_regrant", {s_grant, s_ready}, {2'd0, 4'b0001});

    // asynchronous reset mid-burst
    do_reset();
    repeat (3) step(4'b0001, $urandom, 1'b0);
    req_valid = 4'b0001;
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_outs", {req_ready, fifo_wr_en, fifo_data_in, fifo_level, busy, underflow, fsm_state}, 64'd0);
    check("async_rst_grant", grant_id, 64'd3);
    do_reset();
    step(4'b1111, $urandom, 1'b0);
    step(4'b1111, $urandom, 1'b0);
    check("post_rst_grant", {s_grant, s_busy}, {2'd0, 1'b1});

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] v;
      logic         rd;
      v  = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
      rd = (m_level > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      step(v, $urandom, rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
